// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM command-port arbiter: MCB instruction codes,
// FSM state encoding and the memory beat width.
package vram_arbiter_pkg;

  localparam logic [2:0] INSTR_WR   = 3'b000;
  localparam logic [2:0] INSTR_RD   = 3'b001;
  localparam int         BEAT_W     = 128;
  localparam int         BEAT_BYTES = BEAT_W / 8;

  typedef enum logic [2:0] {
    S_WAIT_CALIB,
    S_IDLE,
    S_ARB,
    S_WR_DATA,
    S_WR_CMD,
    S_RD_CMD
  } state_e;

endpackage

// File: rtl/vram_arbiter_rd_credit_tracker.sv
// Tracks read beats requested from the MCB but not yet delivered, and reports
// whether the read-data path can absorb one more full burst.
module vram_arbiter_rd_credit_tracker
  import vram_arbiter_pkg::*;
#(
  parameter int BURST_BEATS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_accept_i,
  input  logic       rd_beat_i,
  input  logic [7:0] rd_fifo_space_i,
  output logic       credit_ok_o
);

  localparam int            OW    = 9;
  localparam logic [OW-1:0] BEATS = OW'(BURST_BEATS);

  logic [OW-1:0] outstanding_q, outstanding_d;

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_accept_i) outstanding_d = outstanding_d + BEATS;
    if (rd_beat_i)   outstanding_d = outstanding_d - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding_q <= '0;
    else        outstanding_q <= outstanding_d;
  end

  // Widened so a space smaller than outstanding never wraps into a false credit.
  assign credit_ok_o = ({2'b00, rd_fifo_space_i} >= ({1'b0, outstanding_q} + {1'b0, BEATS}));

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    rd_beat_i |-> (outstanding_q != '0));
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the MCB command port between frame-buffer prefetch reads and writebacks.
// Define VRAM_ARB_STATS_EN to add burst/stall statistics outputs latched at vsync.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 30,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_BYTES = 3840000,
  parameter int BURST_BEATS = 4,
  parameter int WR_URGENT   = 48,
  parameter int MAX_RD_RUN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic                  vsync,
  input  logic [7:0]            rd_fifo_space,
  input  logic                  rd_beat,
  input  logic [7:0]            wr_fifo_count,
  output logic                  wr_pop,
  input  logic                  cmd_full,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [ADDR_WIDTH-1:0] cmd_byte_addr,
  output logic                  frame_busy,
  output logic                  overrun
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_rd_bursts,
  output logic [15:0]           stat_wr_bursts,
  output logic [23:0]           stat_stall_cycles
`endif
);

  localparam int                    PW          = ADDR_WIDTH + 1;
  localparam int                    BURST_BYTES = BEAT_BYTES * BURST_BEATS;
  localparam logic [PW-1:0]         FRAME_P     = PW'(FRAME_BYTES);
  localparam logic [PW-1:0]         BB_P        = PW'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BASE_P      = ADDR_WIDTH'(BASE_ADDR);
  localparam int                    RW          = $clog2(MAX_RD_RUN + 1);
  localparam logic [RW-1:0]         RUN_MAX     = RW'(MAX_RD_RUN);
  localparam int                    BCW         = $clog2(BURST_BEATS + 1);
  localparam logic [BCW-1:0]        LAST_BEAT   = BCW'(BURST_BEATS - 1);
  localparam logic [7:0]            CNT_BEATS   = 8'(BURST_BEATS);
  localparam logic [7:0]            CNT_URGENT  = 8'(WR_URGENT);

  state_e         state_q, state_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]  rd_run_q, rd_run_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic           frame_busy_q, frame_busy_d;
  logic           overrun_q, overrun_d;
  logic           restart_q, restart_d;
  logic           credit_ok, rd_accept, wr_elig, rd_elig;

  assign rd_accept = (state_q == S_RD_CMD) && !cmd_full;
  // A write may only cover bytes whose prefetch has already been issued.
  assign wr_elig   = (wr_ptr_q < FRAME_P) && (wr_fifo_count >= CNT_BEATS) &&
                     ((wr_ptr_q + BB_P) <= rd_ptr_q);
  assign rd_elig   = (rd_ptr_q < FRAME_P) && credit_ok;

  vram_arbiter_rd_credit_tracker #(.BURST_BEATS(BURST_BEATS)) u_credit (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_accept_i     (rd_accept),
    .rd_beat_i       (rd_beat),
    .rd_fifo_space_i (rd_fifo_space),
    .credit_ok_o     (credit_ok)
  );

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_run_d      = rd_run_q;
    beat_d        = beat_q;
    frame_busy_d  = frame_busy_q;
    overrun_d     = overrun_q;
    restart_d     = restart_q;
    cmd_en        = 1'b0;
    cmd_instr     = INSTR_WR;
    cmd_byte_addr = '0;
    wr_pop        = 1'b0;

    if (vsync && frame_busy_q && (state_q != S_WAIT_CALIB)) begin
      overrun_d = 1'b1;
      restart_d = 1'b1;
    end

    case (state_q)
      S_WAIT_CALIB: if (calib_done) state_d = S_IDLE;
      S_IDLE: begin
        if (!calib_done) state_d = S_WAIT_CALIB;
        else if (vsync) begin
          rd_ptr_d     = '0;
          wr_ptr_d     = '0;
          frame_busy_d = 1'b1;
          state_d      = S_ARB;
        end
      end
      S_ARB: begin
        if (!calib_done) state_d = S_WAIT_CALIB;
        else if (restart_d) begin
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
          restart_d = 1'b0;
        end else if ((rd_ptr_q == FRAME_P) && (wr_ptr_q == FRAME_P)) begin
          frame_busy_d = 1'b0;
          state_d      = S_IDLE;
        end else if (wr_elig && ((wr_fifo_count >= CNT_URGENT) || (rd_run_q == RUN_MAX)))
          state_d = S_WR_DATA;
        else if (rd_elig) state_d = S_RD_CMD;
        else if (wr_elig) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        wr_pop = 1'b1;
        beat_d = beat_q + BCW'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d   = '0;
          rd_run_d = '0;
          state_d  = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        cmd_en        = 1'b1;
        cmd_instr     = INSTR_WR;
        cmd_byte_addr = BASE_P + wr_ptr_q[ADDR_WIDTH-1:0];
        if (!cmd_full) begin
          wr_ptr_d = wr_ptr_q + BB_P;
          state_d  = calib_done ? S_ARB : S_WAIT_CALIB;
        end
      end
      S_RD_CMD: begin
        cmd_en        = 1'b1;
        cmd_instr     = INSTR_RD;
        cmd_byte_addr = BASE_P + rd_ptr_q[ADDR_WIDTH-1:0];
        if (!cmd_full) begin
          rd_ptr_d = rd_ptr_q + BB_P;
          rd_run_d = (rd_run_q == RUN_MAX) ? rd_run_q : rd_run_q + RW'(1);
          state_d  = calib_done ? S_ARB : S_WAIT_CALIB;
        end
      end
      default: state_d = S_WAIT_CALIB;
    endcase

    // Losing calibration abandons the frame; the next vsync starts a fresh one.
    if (state_d == S_WAIT_CALIB) begin
      frame_busy_d = 1'b0;
      restart_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_CALIB;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_run_q     <= '0;
      beat_q       <= '0;
      frame_busy_q <= 1'b0;
      overrun_q    <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_run_q     <= rd_run_d;
      beat_q       <= beat_d;
      frame_busy_q <= frame_busy_d;
      overrun_q    <= overrun_d;
      restart_q    <= restart_d;
    end
  end

  assign cmd_bl     = 6'(BURST_BEATS - 1);
  assign frame_busy = frame_busy_q;
  assign overrun    = overrun_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic [23:0] stall_cnt_q;
  logic        wr_accept, stall;

  assign wr_accept = (state_q == S_WR_CMD) && !cmd_full;
  assign stall     = ((state_q == S_WR_CMD) || (state_q == S_RD_CMD)) && cmd_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q          <= '0;
      wr_cnt_q          <= '0;
      stall_cnt_q       <= '0;
      stat_rd_bursts    <= '0;
      stat_wr_bursts    <= '0;
      stat_stall_cycles <= '0;
    end else if (vsync) begin
      stat_rd_bursts    <= rd_cnt_q;
      stat_wr_bursts    <= wr_cnt_q;
      stat_stall_cycles <= stall_cnt_q;
      rd_cnt_q          <= {15'd0, rd_accept};
      wr_cnt_q          <= {15'd0, wr_accept};
      stall_cnt_q       <= {23'd0, stall};
    end else begin
      rd_cnt_q          <= rd_cnt_q + {15'd0, rd_accept};
      wr_cnt_q          <= wr_cnt_q + {15'd0, wr_accept};
      stall_cnt_q       <= stall_cnt_q + {23'd0, stall};
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a transaction-level model predicts the command
// stream per frame; a memory-side process drives cmd_full/rd_beat and checks accepts.
module tb_vram_arbiter;

  localparam int AW     = 30;
  localparam int FB     = 256;
  localparam int BBEATS = 4;
  localparam int MAXRUN = 2;
  localparam int URG    = 12;
  localparam int BB     = 16 * BBEATS;
  localparam logic [2:0] I_WR = 3'b000;
  localparam logic [2:0] I_RD = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n, calib_done, vsync, rd_beat, cmd_full;
  logic [7:0]    rd_fifo_space, wr_fifo_count;
  logic          wr_pop, cmd_en, frame_busy, overrun;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   stat_rd_bursts, stat_wr_bursts;
  logic [23:0]   stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_WIDTH(AW), .BASE_ADDR(0), .FRAME_BYTES(FB), .BURST_BEATS(BBEATS),
    .WR_URGENT(URG), .MAX_RD_RUN(MAXRUN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .vsync(vsync),
    .rd_fifo_space(rd_fifo_space), .rd_beat(rd_beat), .wr_fifo_count(wr_fifo_count),
    .wr_pop(wr_pop), .cmd_full(cmd_full), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .frame_busy(frame_busy),
    .overrun(overrun)
`ifdef VRAM_ARB_STATS_EN
    , .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [2:0]    instr;
    logic [AW-1:0] addr;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   beat_grant = 0;
  int   hold_req = 0;
  int   hold_done = 0;
  bit   rand_full = 0;
  int   m_run = 0;

  // Memory-side process: drives cmd_full / rd_beat and scores every accepted command.
  initial begin : mem_side
    int   pending, beats_given, hold_left, pops;
    cmd_t held, e;
    pending = 0; beats_given = 0; hold_left = 0; pops = 0;
    rd_beat = 1'b0; cmd_full = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0; beats_given = 0; hold_left = 0; pops = 0;
        rd_beat = 1'b0; cmd_full = 1'b0;
      end else begin
        if (hold_left > 0) begin
          checks++;
          if (!(cmd_en && cmd_instr == held.instr && cmd_byte_addr == held.addr)) begin
            errors++;
            $display("FAIL hold_stable: en=%0b instr=%0h addr=%0h, required en=1 instr=%0h addr=%0h",
                     cmd_en, cmd_instr, cmd_byte_addr, held.instr, held.addr);
          end
          hold_left--;
        end else if (hold_done < hold_req && cmd_en && cmd_instr == I_RD) begin
          held.instr = cmd_instr;
          held.addr  = cmd_byte_addr;
          hold_left  = 5;
          hold_done++;
        end
        cmd_full = (hold_left > 0) ? 1'b1 : (rand_full ? ($urandom_range(0, 3) == 0) : 1'b0);

        rd_beat = (pending > 0) && (beats_given < beat_grant) && ($urandom_range(0, 1) == 1);
        if (rd_beat) begin
          pending--;
          beats_given++;
        end

        if (wr_pop) pops++;

        if (cmd_en && !cmd_full) begin
          accepts++;
          checks++;
          if (cmd_bl != 6'(BBEATS - 1)) begin
            errors++;
            $display("FAIL cmd_bl: got %0d, required %0d", cmd_bl, BBEATS - 1);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd: instr=%0h addr=%0h with nothing expected",
                     cmd_instr, cmd_byte_addr);
          end else begin
            e = exp_q.pop_front();
            if (e.instr != cmd_instr || e.addr != cmd_byte_addr) begin
              errors++;
              $display("FAIL cmd_order: got instr=%0h addr=%0h, required instr=%0h addr=%0h",
                       cmd_instr, cmd_byte_addr, e.instr, e.addr);
            end
          end
          if (cmd_instr == I_WR) begin
            checks++;
            if (pops != BBEATS) begin
              errors++;
              $display("FAIL wr_pop_len: got %0d pops, required %0d", pops, BBEATS);
            end
            pops = 0;
          end else begin
            pending += BBEATS;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] instr, input int addr);
    cmd_t c;
    c.instr = instr;
    c.addr  = addr[AW-1:0];
    exp_q.push_back(c);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d commands still outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Reference: one frame of command order from the scheduling rules, assuming read credit.
  task automatic model_frame(input int count, input int rp0, input int wp0);
    int rp = rp0;
    int wp = wp0;
    bit we, re;
    while (rp < FB || wp < FB) begin
      we = (wp < FB) && (count >= BBEATS) && (wp + BB <= rp);
      re = (rp < FB);
      if (we && (count >= URG || m_run == MAXRUN)) begin
        push(I_WR, wp); wp += BB; m_run = 0;
      end else if (re) begin
        push(I_RD, rp); rp += BB;
        if (m_run < MAXRUN) m_run++;
      end else if (we) begin
        push(I_WR, wp); wp += BB; m_run = 0;
      end else break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    beat_grant = 0;
    m_run = 0;
    tick(3);
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_wr_pop", wr_pop, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cmd_addr", cmd_byte_addr, 0);
    chk("rst_cmd_bl", cmd_bl, BBEATS - 1);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic run_frame(input string name, input int count);
    wr_fifo_count = 8'(count);
    model_frame(count, 0, 0);
    pulse_vsync();
    wait_drain(name, 3000);
    tick(4);
    chk({name, "_done_busy"}, frame_busy, 0);
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0; calib_done = 1'b0; vsync = 1'b0;
    rd_fifo_space = 8'd8; wr_fifo_count = 8'd0;
    do_reset();

    // Uncalibrated: vsync must be ignored.
    pulse_vsync();
    tick(20);
    chk("calib_gate_cmds", accepts, 0);
    chk("calib_gate_busy", frame_busy, 0);

    // Credit limit: 8 free entries allow two bursts until beats return.
    calib_done = 1'b1;
    tick(3);
    push(I_RD, 0); push(I_RD, 64);
    pulse_vsync();
    wait_drain("credit_two_reads", 200);
    chk("frame_busy_mid", frame_busy, 1);
    n = accepts;
    tick(30);
    chk("credit_stall", accepts, n);
    push(I_RD, 128);
    beat_grant += 4;
    wait_drain("credit_third_read", 200);

    // Reset in the middle of a frame.
    do_reset();

    // Overrun: vsync while stalled after two reads restarts the frame at 0.
    rd_fifo_space = 8'd8; wr_fifo_count = 8'd0;
    push(I_RD, 0); push(I_RD, 64);
    m_run = 2;
    pulse_vsync();
    wait_drain("ovr_first_reads", 200);
    tick(5);
    chk("overrun_clear", overrun, 0);
    pulse_vsync();
    tick(2);
    chk("overrun_set", overrun, 1);
    chk("overrun_busy", frame_busy, 1);
    push(I_RD, 0);
    beat_grant += 4;
    wait_drain("restart_read0", 200);
    beat_grant = 1 << 30;
    rd_fifo_space = 8'd200;
    wr_fifo_count = 8'd8;
    model_frame(8, 64, 0);
    wait_drain("restart_frame", 3000);
    tick(4);
    chk("restart_done_busy", frame_busy, 0);
    chk("overrun_sticky", overrun, 1);

    // Pattern frames: fairness, urgency, held command, then random.
    do_reset();
    beat_grant = 1 << 30;
    rd_fifo_space = 8'd200;
    run_frame("fair_c4", 4);
    run_frame("urgent_c12", 12);
    hold_req++;
    run_frame("hold_c8", 8);
    chk("hold_seen", hold_done, hold_req);
    rand_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_frame("random", int'($urandom_range(4, 15)));
    end
    rand_full = 1'b0;
    chk("no_overrun_idle_vsync", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Schedules the single DDR3 MCB command port between pixel-state prefetch reads (VRAM -> EPDC) and writebacks (EPDC -> VRAM).
- Sits between the bi/bo FIFOs and the memory controller, in the clk_mif domain.
- Walks one frame buffer per frame trigger. Issues fixed-length bursts, holds read-data credits, and keeps writeback from overtaking prefetch.

Parameters:
- ADDR_WIDTH, 30, byte-address width of MCB command port
- BASE_ADDR, 0, byte address of frame buffer start
- FRAME_BYTES, 3840000, bytes per frame (400*4*1200*2); must be a multiple of BURST_BYTES
- BURST_BEATS, 4, 128-bit beats per burst (BURST_BYTES = 16*BURST_BEATS)
- WR_URGENT, 48, wr_fifo_count at/above which writes win unconditionally
- MAX_RD_RUN, 4, consecutive read bursts before a pending write gets priority

Ports:
- clk  in  1  clk_mif
- rst_n  in  1  asynchronous, active-low reset
- calib_done  in  1  DDR calibration complete (same domain)
- vsync  in  1  one-cycle frame trigger, already synchronised
- rd_fifo_space  in  8  free 128-bit entries in read-data path
- rd_beat  in  1  one read beat delivered by MCB this cycle
- wr_fifo_count  in  8  128-bit entries waiting in writeback FIFO
- wr_pop  out  1  pop writeback FIFO and push MCB write FIFO this cycle
- cmd_full  in  1  MCB command FIFO full
- cmd_en  out  1  command strobe
- cmd_instr  out  3  3'b000 write, 3'b001 read
- cmd_bl  out  6  BURST_BEATS-1
- cmd_byte_addr  out  ADDR_WIDTH  burst start address
- frame_busy  out  1  current frame not fully read and written
- overrun  out  1  sticky: vsync arrived while frame_busy

Behaviour:
- Reset values:
  - Outputs: all outputs 0; cmd_bl constant.
  - Internals: rd_ptr = wr_ptr = 0, outstanding = 0, rd_run = 0, state WAIT_CALIB.
- States: WAIT_CALIB, IDLE, ARB, WR_DATA, WR_CMD, RD_CMD.
- WAIT_CALIB: leaves to IDLE on calib_done = 1. calib_done falling anywhere returns to WAIT_CALIB only after the current burst completes.
- IDLE -> ARB on vsync.
  - Pointers zeroed, frame_busy = 1.
  - vsync in WAIT_CALIB is ignored.
- ARB decides in 1 cycle. Read credit holds when rd_fifo_space - outstanding >= BURST_BEATS (unsigned, 9-bit compare).
  - Write eligibility: wr_ptr < FRAME_BYTES, wr_fifo_count >= BURST_BEATS, and wr_ptr + BURST_BYTES <= rd_ptr (never overtake prefetch).
  - Read eligibility: rd_ptr < FRAME_BYTES and read credit holds.
  - Priority order:
    - (1) write if eligible and wr_fifo_count >= WR_URGENT;
    - (2) write if eligible and rd_run == MAX_RD_RUN;
    - (3) read if eligible;
    - (4) write if eligible;
    - else stay in ARB.
  - Frame completion: both pointers == FRAME_BYTES -> IDLE, frame_busy = 0.
- WR_DATA:
  - wr_pop high for exactly BURST_BEATS consecutive cycles; FIFO count already guaranteed.
  - Then WR_CMD; rd_run cleared.
- WR_CMD: cmd_en = 1, instr write, addr = BASE_ADDR + wr_ptr, held until cmd_full = 0 in the same cycle. wr_ptr += BURST_BYTES, -> ARB.
- RD_CMD:
  - Same hold rule on cmd_full; addr = BASE_ADDR + rd_ptr.
  - On accept: rd_ptr += BURST_BYTES, outstanding += BURST_BEATS, rd_run saturating +1.
- cmd_en is asserted only in WR_CMD/RD_CMD; at most one command per accepted handshake.
- outstanding:
  - Decrements by 1 per rd_beat in any state.
  - Simultaneous accept + rd_beat nets +BURST_BEATS-1.
  - Underflow impossible by construction; assertion in sim.
- vsync while frame_busy:
  - overrun set (sticky until reset).
  - Pending restart flag is set. The in-flight burst completes (WR_DATA is never aborted).
  - At next ARB, pointers are zeroed and the frame restarts. outstanding is NOT cleared.
- vsync while IDLE: starts the frame, no overrun.
- Reset mid-burst: immediate return to reset values. The upstream FIFOs are reset by the same sys_rst.

Optional Feature:
- VRAM_ARB_STATS_EN defined: adds outputs stat_rd_bursts[15:0], stat_wr_bursts[15:0], stat_stall_cycles[23:0].
  - Counters count accepted reads, accepted writes, and cycles in a CMD state with cmd_full = 1.
  - Values latched at each vsync; live counters then clear.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared header vram_defs.vh holds:
  - MCB instr encodings (INSTR_WR, INSTR_RD);
  - state encodings;
  - beat width 128.
- One natural sub-module: rd_credit_tracker, which holds outstanding, increments on accept, decrements on rd_beat, and outputs the credit_ok compare.

Test Plan:
- Bench parameters: FRAME_BYTES=256, BURST_BEATS=4, MAX_RD_RUN=2, WR_URGENT=12.
- Reset/calib: rst_n low then high, calib_done=0, vsync pulse -> no cmd_en. Then calib_done=1, vsync -> first cmd read @0x0, cmd_bl=3.
- Credit limit: rd_fifo_space=8, no rd_beat -> exactly 2 reads (0x0, 0x40), then stall. Pulse rd_beat x4 -> third read @0x80.
- No overtake: wr_fifo_count=8 after vsync -> first write only after read @0x0 accepted; write addr 0x0.
- Fairness/urgency:
  - wr_fifo_count=4, ample space -> sequence R0, R40, W0, R80...
  - wr_fifo_count=12 -> write chosen ahead of the eligible read.
- cmd_full: hold cmd_full=1 for 5 cycles during RD_CMD -> cmd_en and address stable for 5 cycles, single accept.
- Overrun: vsync after 2 of 4 reads -> overrun=1, in-flight burst completes, next cmd is read @0x0. Full frame then -> frame_busy falls once both pointers reach 256.
